// File: rtl/detection_event_logger.sv
// Timestamps upstream detection pulses with the serial-bit index and queues them in a
// show-ahead FIFO drained by valid/ready; also keeps a saturating count and sticky overflow.
module detection_event_logger #(
  parameter int IDX_W = 8,
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_det_in,
  input  logic                       i_clear,
  input  logic                       i_evt_ready,
  output logic                       o_evt_valid,
  output logic [IDX_W-1:0]           o_evt_pos,
  output logic [CNT_W-1:0]           o_det_count,
  output logic                       o_overflow,
  output logic [$clog2(DEPTH):0]     o_fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [IDX_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [LW-1:0]    r_level;
  logic [IDX_W-1:0] r_bit_idx;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_pop   = i_evt_ready & ~w_empty & ~i_clear;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push  = i_det_in & ~i_clear & (~w_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= r_bit_idx;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_idx <= '0;
      r_wr      <= '0;
      r_rd      <= '0;
      r_level   <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
    end else if (i_clear) begin
      // The clear cycle itself consumes index 0, so the next sampled bit is index 1.
      r_bit_idx <= IDX_W'(1);
      r_wr      <= '0;
      r_rd      <= '0;
      r_level   <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_bit_idx <= r_bit_idx + 1'b1;
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (i_det_in && (r_count != '1)) r_count <= r_count + 1'b1;
      if (i_det_in && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign o_evt_valid  = ~w_empty;
  assign o_evt_pos    = w_empty ? '0 : r_mem[r_rd];
  assign o_det_count  = r_count;
  assign o_overflow   = r_ovf;
  assign o_fifo_level = r_level;

endmodule

// File: tb/tb_detection_event_logger.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed
// scenarios with literal expectations and a randomized phase.
module tb_detection_event_logger;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       det_in = 1'b0;
  logic       clear = 1'b0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [7:0] evt_pos;
  logic [7:0] det_count;
  logic       overflow;
  logic [2:0] fifo_level;

  detection_event_logger #(.IDX_W(8), .CNT_W(8), .DEPTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_det_in(det_in), .i_clear(clear),
    .i_evt_ready(evt_ready), .o_evt_valid(evt_valid), .o_evt_pos(evt_pos),
    .o_det_count(det_count), .o_overflow(overflow), .o_fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // reference model
  int m_idx;
  int m_q[$];
  int m_cnt;
  bit m_ovf;
  logic [6:0] hist;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_idx = 0; m_q.delete(); m_cnt = 0; m_ovf = 1'b0;
  endfunction

  function automatic void model_step(input bit d, input bit c, input bit r);
    bit pop, full;
    if (c) begin
      m_q.delete(); m_cnt = 0; m_ovf = 1'b0; m_idx = 1;
    end else begin
      pop  = (m_q.size() > 0) && r;
      full = (m_q.size() == 4);
      if (pop) void'(m_q.pop_front());
      if (d) begin
        if (full && !pop) m_ovf = 1'b1;
        else m_q.push_back(m_idx);
        if (m_cnt < 255) m_cnt++;
      end
      m_idx = (m_idx + 1) % 256;
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("valid", int'(evt_valid), int'(m_q.size() > 0));
      chk("pos", int'(evt_pos), (m_q.size() > 0) ? m_q[0] : 0);
      chk("count", int'(det_count), m_cnt);
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("level", int'(fifo_level), m_q.size());
    end
  end

  task automatic tick(input bit d, input bit c, input bit r);
    det_in = d; clear = c; evt_ready = r;
    @(posedge clk);
    model_step(d, c, r);
    @(negedge clk);
    #1;
  endtask

  task automatic send_bit(input bit b, input bit r);
    hist = {hist[5:0], b};
    tick(hist == 7'b0100110, 1'b0, r);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; det_in = 1'b0; clear = 1'b0; evt_ready = 1'b0;
    #1;
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_pos", int'(evt_pos), 0);
    chk("rst_count", int'(det_count), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_level", int'(fifo_level), 0);
    model_reset();
    hist = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    bit [12:0] s2;
    model_reset();
    hist = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;

    // single detection from serial stream 0100110
    do_reset();
    for (int i = 0; i < 7; i++) send_bit(7'b0100110 >> (6 - i), 1'b0);
    chk("s1_pos", int'(evt_pos), 6);
    chk("s1_count", int'(det_count), 1);
    chk("s1_level", int'(fifo_level), 1);
    tick(1'b0, 1'b0, 1'b1);
    chk("s1_drained", int'(evt_valid), 0);

    // overlapping stream 0100110100110
    do_reset();
    s2 = 13'b0100110100110;
    for (int i = 12; i >= 0; i--) send_bit(s2[i], 1'b0);
    chk("s2_level", int'(fifo_level), 2);
    chk("s2_head0", int'(evt_pos), 6);
    tick(1'b0, 1'b0, 1'b1);
    chk("s2_head1", int'(evt_pos), 12);
    tick(1'b0, 1'b0, 1'b1);
    chk("s2_empty", int'(evt_valid), 0);

    // overflow: detections at 3,5,7,9,11
    do_reset();
    for (int i = 0; i < 12; i++) tick((i % 2 == 1) && i >= 3, 1'b0, 1'b0);
    chk("s3_level", int'(fifo_level), 4);
    chk("s3_ovf", int'(overflow), 1);
    chk("s3_count", int'(det_count), 5);
    for (int k = 0; k < 4; k++) begin
      chk("s3_drain", int'(evt_pos), 3 + 2 * k);
      tick(1'b0, 1'b0, 1'b1);
    end
    chk("s3_ovf_sticky", int'(overflow), 1);

    // full FIFO, simultaneous push and pop at index 20
    do_reset();
    for (int i = 0; i < 20; i++) tick(i >= 16, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    chk("s4_level", int'(fifo_level), 4);
    chk("s4_ovf", int'(overflow), 0);
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 1'b1);
    chk("s4_last", int'(evt_pos), 20);
    tick(1'b0, 1'b0, 1'b1);
    chk("s4_empty", int'(evt_valid), 0);

    // continuous detections with draining: saturation and index wrap
    do_reset();
    for (int i = 0; i < 300; i++) begin
      tick(1'b1, 1'b0, 1'b1);
      if (i == 255) chk("s5_pos255", int'(evt_pos), 255);
      if (i == 256) chk("s5_wrap", int'(evt_pos), 0);
    end
    chk("s5_sat", int'(det_count), 255);
    chk("s5_level", int'(fifo_level), 1);

    // asynchronous reset mid-queue, then clear with coincident detection
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
    chk("s6_level_pre", int'(fifo_level), 3);
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    chk("s6_clr_valid", int'(evt_valid), 0);
    chk("s6_clr_count", int'(det_count), 0);
    chk("s6_clr_level", int'(fifo_level), 0);
    tick(1'b1, 1'b0, 1'b0);
    chk("s6_idx_after_clear", int'(evt_pos), 1);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(2) == 0, $urandom_range(99) == 0, $urandom_range(1) == 1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
